bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_to_bin_seq.sv | 151 +++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
// Sequential BCD-to-binary converter using iterative reverse double-dabble.
// One shift-and-correct step per clock; NB steps convert DIGITS BCD digits.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_start  start request, sampled only while idle
//   i_bcd    packed BCD input, [3:0] = ones digit
//   o_bin    converted value (low W bits of the result), held between runs
//   o_busy   high while shifting
//   o_done   one-cycle completion pulse
//   o_ovf    result does not fit in W bits, held until next accepted start
//   o_err    an input digit was > 9, held until next accepted start
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int W      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_bcd,
  output logic [W-1:0]          o_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ovf,
  output logic                  o_err
);

  localparam int NB = $clog2(10**DIGITS);
  localparam int CW = $clog2(NB+1);
  localparam int BW = 4*DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   bcd_reg, bcd_next;
  logic [NB-1:0]   bin_reg, bin_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [W-1:0]    out_bin_reg, out_bin_next;
  logic            ovf_reg, ovf_next;
  logic            err_reg, err_next;

  // One step of the working register: shift right, then correct digits.
  logic [BW-1:0]   bcd_shift;
  logic [BW-1:0]   bcd_fix;
  logic [NB-1:0]   bin_shift;
  logic [W-1:0]    bin_low;
  logic            ovf_shift;
  logic [DIGITS-1:0] dig_ok;
  logic            digits_ok;

  assign {bcd_shift, bin_shift} = {bcd_reg, bin_reg} >> 1;

  // A digit that was >= 5 before the shift lands at >= 8 afterwards;
  // subtracting 3 undoes the +3 that forward double-dabble would have added.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_fix[4*gi +: 4] = (bcd_shift[4*gi +: 4] >= 4'd8)
                                  ? bcd_shift[4*gi +: 4] - 4'd3
                                  : bcd_shift[4*gi +: 4];
      assign dig_ok[gi] = (i_bcd[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  assign digits_ok = &dig_ok;

  // Truncating cast also zero-extends when W exceeds NB.
  assign bin_low = W'(bin_shift);

  generate
    if (NB > W) begin : g_ovf
      assign ovf_shift = |bin_shift[NB-1:W];
    end else begin : g_no_ovf
      assign ovf_shift = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      bcd_reg     <= '0;
      bin_reg     <= '0;
      cnt_reg     <= '0;
      out_bin_reg <= '0;
      ovf_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bcd_reg     <= bcd_next;
      bin_reg     <= bin_next;
      cnt_reg     <= cnt_next;
      out_bin_reg <= out_bin_next;
      ovf_reg     <= ovf_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bcd_next     = bcd_reg;
    bin_next     = bin_reg;
    cnt_next     = cnt_reg;
    out_bin_next = out_bin_reg;
    ovf_next     = ovf_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (digits_ok) begin
            bcd_next   = i_bcd;
            bin_next   = '0;
            cnt_next   = CW'(NB);
            ovf_next   = 1'b0;
            err_next   = 1'b0;
            state_next = SHIFT;
          end else begin
            // Invalid digit: report immediately, keep the previous o_bin.
            err_next   = 1'b1;
            ovf_next   = 1'b0;
            state_next = DONE;
          end
        end
      end
      SHIFT: begin
        bcd_next = bcd_fix;
        bin_next = bin_shift;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          // Publish the final step directly so results align with o_done.
          out_bin_next = bin_low;
          ovf_next     = ovf_shift;
          state_next   = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_bin  = out_bin_reg;
  assign o_ovf  = ovf_reg;
  assign o_err  = err_reg;
  assign o_busy = (state_reg == SHIFT);
  assign o_done = (state_reg == DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (DIGITS=3, W=8).
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_seq #(.DIGITS(3), .W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_bcd   (bcd),
    .o_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_ovf   (ovf),
    .o_err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge, then observe ncyc cycles (cycle 1 follows the
  // accepting edge). Returns to the caller at #1 after a rising edge.
  task automatic run_conv(input logic [11:0] v, input int ncyc,
                          output int done_cyc, output int busy_cnt,
                          output int done_cnt, output logic [7:0] bin_s,
                          output logic ovf_s, output logic err_s);
    done_cyc = 0; busy_cnt = 0; done_cnt = 0;
    bin_s = 'x; ovf_s = 1'bx; err_s = 1'bx;
    bcd = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = k; bin_s = bin; ovf_s = ovf; err_s = err;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bcd = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bin, busy, done, ovf, err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got bin=%0d busy=%b done=%b ovf=%b err=%b, want all 0",
               bin, busy, done, ovf, err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, bc, nc; logic [7:0] b; logic o, e;
    run_conv(12'h123, 14, dc, bc, nc, b, o, e);
    checks++;
    if (bc !== 10) begin errors++; $display("FAIL basic_busy_cycles: got %0d, want 10", bc); end
    checks++;
    if (dc !== 11) begin errors++; $display("FAIL basic_done_cycle: got %0d, want 11", dc); end
    checks++;
    if (nc !== 1) begin errors++; $display("FAIL basic_done_count: got %0d, want 1", nc); end
    checks++;
    if ({b, o, e} !== {8'd123, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_result: got bin=%0d ovf=%b err=%b, want 123 0 0", b, o, e);
    end
    $display("basic 123: bin=%0d ovf=%b err=%b done_cycle=%0d", b, o, e, dc);
  endtask

  task automatic test_values();
    logic [11:0] vin [4] = '{12'h255, 12'h256, 12'h999, 12'h000};
    logic [7:0]  vb  [4] = '{8'd255, 8'd0, 8'd231, 8'd0};
    logic        vo  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int dc, bc, nc; logic [7:0] b; logic o, e;
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], 12, dc, bc, nc, b, o, e);
      checks++;
      if ({b, o, e} !== {vb[i], vo[i], 1'b0} || dc !== 11) begin
        errors++;
        $display("FAIL value_%03h: got bin=%0d ovf=%b err=%b cyc=%0d, want bin=%0d ovf=%b err=0 cyc=11",
                 vin[i], b, o, e, dc, vb[i], vo[i]);
      end
      $display("value %03h: bin=%0d ovf=%b", vin[i], b, o);
    end
  endtask

  task automatic test_sweep();
    int dc, bc, nc; logic [7:0] b; logic o, e;
    logic [11:0] v; int bad = 0;
    for (int n = 0; n < 1000; n++) begin
      v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      run_conv(v, 11, dc, bc, nc, b, o, e);
      checks++;
      if (b !== 8'(n % 256) || o !== (n > 255) || e !== 1'b0 || dc !== 11) begin
        errors++; bad++;
        $display("FAIL sweep_%0d: got bin=%0d ovf=%b err=%b cyc=%0d, want bin=%0d ovf=%b err=0 cyc=11",
                 n, b, o, e, dc, n % 256, (n > 255));
      end
    end
    $display("sweep 000..999: %0d bad", bad);
  endtask

  task automatic test_err();
    int dc, bc, nc; logic [7:0] b; logic o, e;
    run_conv(12'h123, 12, dc, bc, nc, b, o, e);
    run_conv(12'h1A3, 4, dc, bc, nc, b, o, e);
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL err_done_cycle: got %0d, want 1", dc); end
    checks++;
    if (bc !== 0) begin errors++; $display("FAIL err_busy: got %0d busy cycles, want 0", bc); end
    checks++;
    if ({b, o, e} !== {8'd123, 1'b0, 1'b1}) begin
      errors++; $display("FAIL err_result: got bin=%0d ovf=%b err=%b, want 123 0 1", b, o, e);
    end
    checks++;
    if (err !== 1'b1 || bin !== 8'd123) begin
      errors++; $display("FAIL err_hold: got err=%b bin=%0d, want 1 123", err, bin);
    end
    $display("err 1A3: bin=%0d err=%b done_cycle=%0d", b, e, dc);
    run_conv(12'h042, 12, dc, bc, nc, b, o, e);
    checks++;
    if ({b, o, e} !== {8'd42, 1'b0, 1'b0}) begin
      errors++; $display("FAIL err_clear: got bin=%0d ovf=%b err=%b, want 42 0 0", b, o, e);
    end
    $display("after err 042: bin=%0d err=%b", b, e);
  endtask

  task automatic test_ignore_start();
    int dc = 0, nc = 0; logic [7:0] b = 'x;
    bcd = 12'h123; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin start = 1'b1; bcd = 12'h777; end
      if (k == 6) begin start = 1'b0; bcd = 12'h999; end
      if (done) begin
        nc++;
        if (dc == 0) begin dc = k; b = bin; end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nc !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d, want 1", nc); end
    checks++;
    if (b !== 8'd123 || dc !== 11) begin
      errors++; $display("FAIL ignore_result: got bin=%0d cyc=%0d, want 123 11", b, dc);
    end
    $display("ignore start: bin=%0d dones=%0d", b, nc);
  endtask

  task automatic test_back_to_back();
    int d1 = 0, d2 = 0;
    bcd = 12'h021; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 24) start = 1'b0;
      if (done) begin
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
        checks++;
        if (bin !== 8'd21) begin
          errors++; $display("FAIL b2b_result: got bin=%0d at cycle %0d, want 21", bin, k);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (d1 !== 11 || d2 !== 23) begin
      errors++; $display("FAIL b2b_spacing: got done cycles %0d,%0d, want 11,23", d1, d2);
    end
    $display("back-to-back: done cycles %0d %0d", d1, d2);
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    int nc = 0; int dc, bc, n2; logic [7:0] b; logic o, e;
    bcd = 12'h123; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bin, busy, done, ovf, err} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_outputs: got bin=%0d busy=%b done=%b ovf=%b err=%b, want all 0",
               bin, busy, done, ovf, err);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst_n = 1'b1;
      if (done) nc++;
    end
    checks++;
    if (nc !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d dones, want 0", nc); end
    run_conv(12'h050, 12, dc, bc, n2, b, o, e);
    checks++;
    if ({b, o, e} !== {8'd50, 1'b0, 1'b0} || dc !== 11) begin
      errors++; $display("FAIL midrst_after: got bin=%0d ovf=%b err=%b cyc=%0d, want 50 0 0 11", b, o, e, dc);
    end
    $display("mid reset then 050: bin=%0d", b);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_sweep();
    test_err();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
